// File: rtl/usb_pkg.sv
// Shared USB serial-path definitions: destuffer state encoding and the
// bit-stuffing run length used by both the transmit stuffer and receive destuffer.
package usb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RECV  = 2'b01,
        STRIP = 2'b10,
        ERROR = 2'b11
    } unstuff_state_t;

    localparam int USB_STUFF_RUN = 6;

endpackage

// File: rtl/bit_unstuff.sv
// Receive-side bit destuffer: drops the zero inserted after every run of MAX_ONES
// ones. Build option UNSTUFF_ERR_CHECK_EN flags a one in the stuffed-bit slot.
//
// state | meaning
// IDLE  | no packet open, waiting for stream_begin
// RECV  | forwarding bits, counting consecutive ones
// STRIP | next valid bit is the stuffed bit and is dropped
// ERROR | stuff violation seen, bits suppressed until stream_end
module bit_unstuff
    import usb_pkg::*;
#(
    parameter int MAX_ONES = USB_STUFF_RUN
) (
    input  logic clk,
    input  logic rst_L,
    input  logic in,
    input  logic in_valid,
    input  logic stream_begin,
    input  logic stream_end,
    output logic out,
    output logic out_valid,
    output logic unstuff_done,
    output logic stuff_err
);

    localparam int CW = $clog2(MAX_ONES + 1);
    localparam logic [CW-1:0] LAST_ONE = CW'(MAX_ONES - 1);

    unstuff_state_t state, state_nxt;
    logic [CW-1:0]  count, count_nxt;
    logic           out_nxt, out_valid_nxt, done_nxt;

`ifdef UNSTUFF_ERR_CHECK_EN
    logic err_q, err_nxt;
`endif

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state        <= IDLE;
            count        <= '0;
            out          <= 1'b0;
            out_valid    <= 1'b0;
            unstuff_done <= 1'b0;
`ifdef UNSTUFF_ERR_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            out          <= out_nxt;
            out_valid    <= out_valid_nxt;
            unstuff_done <= done_nxt;
`ifdef UNSTUFF_ERR_CHECK_EN
            err_q        <= err_nxt;
`endif
        end
    end

    // stream_end outranks everything once a packet is open; stream_begin restarts
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        if (state == IDLE) begin
            if (stream_begin && !stream_end) begin
                state_nxt = RECV;
                count_nxt = '0;
            end
        end else if (stream_end) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else if (stream_begin) begin
            state_nxt = RECV;
            count_nxt = '0;
        end else begin
            case (state)
                RECV: begin
                    if (in_valid) begin
                        if (in && count == LAST_ONE) begin
                            state_nxt = STRIP;
                            count_nxt = '0;
                        end else if (in) begin
                            count_nxt = count + 1'b1;
                        end else begin
                            count_nxt = '0;
                        end
                    end
                end
                STRIP: begin
                    if (in_valid) begin
                        count_nxt = '0;
`ifdef UNSTUFF_ERR_CHECK_EN
                        state_nxt = in ? ERROR : RECV;
`else
                        state_nxt = RECV;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_nxt       = out;
        out_valid_nxt = 1'b0;
        done_nxt      = 1'b0;
`ifdef UNSTUFF_ERR_CHECK_EN
        err_nxt       = err_q;
`endif
        if (stream_end) begin
            done_nxt = (state != IDLE);
        end else if (stream_begin) begin
`ifdef UNSTUFF_ERR_CHECK_EN
            err_nxt = 1'b0;
`endif
        end else if (state == RECV && in_valid) begin
            out_nxt       = in;
            out_valid_nxt = 1'b1;
        end
`ifdef UNSTUFF_ERR_CHECK_EN
        else if (state == STRIP && in_valid && in) begin
            err_nxt = 1'b1;
        end
`endif
    end

`ifdef UNSTUFF_ERR_CHECK_EN
    assign stuff_err = err_q;
`else
    assign stuff_err = 1'b0;
`endif

endmodule

// File: tb/tb_bit_unstuff.sv
// Scoreboard bench for bit_unstuff: a run-length reference model predicts each
// cycle's outputs; a monitor compares them one step after every rising edge.
module tb_bit_unstuff;

    localparam int RUN = 6;

    logic clk = 1'b0;
    logic rst_L;
    logic in_bit, in_valid, stream_begin, stream_end;
    logic out, out_valid, unstuff_done, stuff_err;

    bit_unstuff dut (
        .clk          (clk),
        .rst_L        (rst_L),
        .in           (in_bit),
        .in_valid     (in_valid),
        .stream_begin (stream_begin),
        .stream_end   (stream_end),
        .out          (out),
        .out_valid    (out_valid),
        .unstuff_done (unstuff_done),
        .stuff_err    (stuff_err)
    );

    always #5 clk = ~clk;

`ifdef UNSTUFF_ERR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // expected per-cycle control {valid, done, err}, and expected data bits
    logic [2:0] ctl_q[$];
    bit         data_q[$];

    // reference model: open packet, run of forwarded ones, pending stuffed bit
    bit m_open, m_skip, m_dead, m_err;
    int m_run;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_skip = 0; m_dead = 0; m_err = 0; m_run = 0;
    endtask

    task automatic model_open();
        m_open = 1; m_skip = 0; m_dead = 0; m_err = 0; m_run = 0;
    endtask

    task automatic step(input bit sb, input bit se, input bit v, input bit b);
        bit ev, ed;
        @(negedge clk);
        stream_begin = sb;
        stream_end   = se;
        in_valid     = v;
        in_bit       = b;
        ev = 0;
        ed = 0;
        if (!m_open) begin
            if (sb && !se) model_open();
        end else if (se) begin
            m_open = 0;
            ed = 1;
        end else if (sb) begin
            model_open();
        end else if (v && !m_dead) begin
            if (m_skip) begin
                m_skip = 0;
                m_run  = 0;
                if (b && CHECK_EN) begin
                    m_err  = 1;
                    m_dead = 1;
                end
            end else begin
                ev = 1;
                data_q.push_back(b);
                m_run = b ? m_run + 1 : 0;
                if (m_run == RUN) m_skip = 1;
            end
        end
        ctl_q.push_back({ev, ed, m_err});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_out", out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", unstuff_done, 0);
        chk("rst_err", stuff_err, 0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        stream_begin = 0; stream_end = 0; in_valid = 0; in_bit = 0;
        rst_L = 0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_L = 1;
    endtask

    always begin
        logic [2:0] e;
        bit d;
        @(posedge clk);
        #1;
        if (ctl_q.size() > 0) begin
            e = ctl_q.pop_front();
            chk("out_valid", out_valid, e[2]);
            chk("unstuff_done", unstuff_done, e[1]);
            chk("stuff_err", stuff_err, e[0]);
            if (out_valid === 1'b1) begin
                if (data_q.size() == 0) begin
                    chk("data_underflow", 1, 0);
                end else begin
                    d = data_q.pop_front();
                    chk("out_bit", out, d);
                end
            end
        end
    end

    initial begin
        int len;
        rst_L = 0; stream_begin = 0; stream_end = 0; in_valid = 0; in_bit = 0;
        model_reset();
        #2;
        check_reset_outputs();
        @(negedge clk);
        rst_L = 1;
        idle(2);

        // stuffed zero removed; bit after it forwarded
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        idle(2);

        // stall while the stuffed bit is pending
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        idle(2);

        // seven ones: violation when checking is built in, silent drop otherwise
        step(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        step(0, 1, 1, 1);
        idle(2);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        idle(1);

        // reset in the middle of a packet with four ones counted
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
        async_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, i != 6);
        step(0, 1, 0, 0);
        idle(1);

        // stream_end with a valid bit at count 5, then begin+end together
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        idle(1);
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        idle(1);

        // minimum packet, and stream_end while idle
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 1);
        idle(1);

        for (int p = 0; p < 40; p++) begin
            step(1, 0, 0, 0);
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++)
                step(($urandom % 64) == 0, 0, ($urandom % 4) != 0, ($urandom % 8) != 0);
            step($urandom % 2, 1, $urandom % 2, $urandom % 2);
            idle($urandom_range(0, 3));
        end

        idle(3);
        chk("data_drained", data_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_unstuff.md
# bit_unstuff

Receive-side bit destuffer for the USB serial path. Sits after the NRZI decoder and ahead of the receive shift/PID/CRC logic. Removes the zero the transmit stuffer inserts after every run of six consecutive ones. Flags a stuff violation when a one appears where a stuffed zero belongs.

## Interface
- MAX_ONES, 6, run length of consecutive ones after which the next bit is a stuffed bit; counter width is $clog2(MAX_ONES+1)
- clk  input  1  single clock; all state changes on posedge
- rst_L  input  1  reset, asynchronous, active-low
- in  input  1  decoded serial bit
- in_valid  input  1  qualifies `in` for this cycle
- stream_begin  input  1  one-cycle pulse: packet starts; bits accepted from the next cycle
- stream_end  input  1  one-cycle pulse: EOP seen; the bit in this cycle is discarded
- out  output  1  destuffed bit, registered
- out_valid  output  1  `out` carries a data bit this cycle
- unstuff_done  output  1  one-cycle pulse after a packet closes
- stuff_err  output  1  sticky stuff violation for the current packet

## Operation
- Reset values: state IDLE, count 0, out 0, out_valid 0, unstuff_done 0, stuff_err 0.
- States: IDLE, RECV, STRIP, ERROR.
- out_valid defaults to 0 every cycle. unstuff_done defaults to 0 every cycle.
- **IDLE**
  - On stream_begin (with no stream_end): go to RECV, count to 0, stuff_err to 0.
  - Otherwise hold.
- **RECV**, with in_valid high:
  - out = in, out_valid = 1.
  - If in = 1 and count = MAX_ONES-1: go to STRIP, count to 0.
  - Else if in = 1: count + 1.
  - Else: count to 0.
- **RECV**, with in_valid low: hold state and count; out holds its last value.
- **STRIP**, on the next valid bit (out_valid stays 0):
  - in = 0: go to RECV, count to 0.
  - in = 1: behaviour set by Configuration.
  - Cycles with in_valid low wait in STRIP.
- **ERROR**: all bits are ignored; out_valid stays 0.
- **stream_end** has priority over everything else in RECV, STRIP and ERROR:
  - Go to IDLE, count to 0, unstuff_done = 1 next cycle.
  - The coincident bit is not forwarded.
  - stuff_err holds its value.
- **stream_end in IDLE**: no effect.
- **stream_begin outside IDLE** (without stream_end): restart. Go to RECV, count to 0, stuff_err to 0, no unstuff_done.
- **Reset mid-packet**: immediate return to reset values. No done pulse.

## Timing
- Latency is one cycle: in/in_valid at edge N appear on out/out_valid after edge N.
- The stuffed bit produces a one-cycle out_valid gap, or more if in_valid stalls.
- unstuff_done is asserted for exactly the one cycle after the edge that sampled stream_end.
- stuff_err rises on the edge that samples the offending bit. It stays high until the next stream_begin or reset.
- Minimum packet: stream_begin at edge N, stream_end at edge N+1 → unstuff_done high after N+1, no out_valid.

## Configuration
- Macro: UNSTUFF_ERR_CHECK_EN.
- **Defined**: a one in STRIP sets stuff_err and moves to ERROR. The packet's remaining bits are suppressed until stream_end.
- **Undefined**: a one in STRIP is dropped exactly like a zero, then return to RECV with count 0. stuff_err is tied to 0 and the ERROR state is not built.

## Structure
- Shared package usb_pkg holds:
  - unstuff state enum (logic [1:0]: IDLE=00, RECV=01, STRIP=10, ERROR=11)
  - localparam USB_STUFF_RUN = 6, used as the MAX_ONES default
  - the same constant is used by the transmit stuffer
- Single module, no sub-module. The run counter is too small to warrant one.

## Test plan
- Reset mid-RECV with count 4 → all outputs 0 the same cycle; the next stream_begin starts cleanly.
- stream_begin, then bits 1,1,1,1,1,1,0,1 every cycle → out_valid bits 1,1,1,1,1,1,(gap),1; stuff_err 0.
- Same stream with in_valid dropped for 3 cycles while in STRIP, then 0,0 → exactly one bit removed; output 1×6, 0.
- With UNSTUFF_ERR_CHECK_EN: 1×7 → stuff_err high after the 7th bit's edge, no further out_valid. stream_end → unstuff_done one cycle, stuff_err still 1. Next stream_begin clears stuff_err.
- Without the macro, same 1×7 stimulus → stuff_err 0; output 1×6; the 7th bit is dropped and counting restarts at 0.
- stream_end coincident with a valid bit in RECV at count 5 → bit not forwarded; IDLE; unstuff_done 1 cycle. stream_begin and stream_end in the same RECV cycle → stream_end wins.
